// File: rtl/bp_pkg.sv
// Definitions shared by both ends of the BytePipe register link: command
// byte layout, the target's register addresses and the initiator state set.
package bp_pkg;

   localparam int BP_CMD_WR_BIT = 7;
   localparam int BP_ADDR_W     = 7;
   localparam int BP_BURST_ADDR = 0;

   // Target register map: the burst-length register lives at the burst address.
   localparam logic [BP_ADDR_W-1:0] BP_REG_BURST_LEN = 7'(BP_BURST_ADDR);

   typedef enum logic [2:0] {
      IDLE,
      SEND_BLEN_CMD,
      SEND_BLEN,
      DISCARD,
      SEND_CMD,
      SEND_DATA,
      RECV
   } bp_init_state_t;

   function automatic logic [7:0] bp_cmd(input logic wr, input logic [BP_ADDR_W-1:0] addr);
      logic [7:0] c;
      c                = {1'b0, addr};
      c[BP_CMD_WR_BIT] = wr;
      return c;
   endfunction

endpackage

// File: rtl/bp_reg_initiator.sv
// Host-side BytePipe initiator: turns one register request at a time into
// command/data bytes and streams the target's reply bytes back out.
module bp_reg_initiator
   import bp_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int BURST_ADDR     = BP_BURST_ADDR
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_cg,
   input  logic       i_req_valid,
   output logic       o_req_ready,
   input  logic       i_req_wr,
   input  logic [6:0] i_req_addr,
   input  logic [7:0] i_req_data,
   input  logic [7:0] i_req_len,
   output logic [7:0] o_bp_data,
   output logic       o_bp_valid,
   input  logic       i_bp_ready,
   input  logic [7:0] i_bp_data,
   input  logic       i_bp_valid,
   output logic       o_bp_ready,
   output logic [7:0] o_rsp_data,
   output logic       o_rsp_valid,
   input  logic       i_rsp_ready,
   output logic       o_rsp_last,
   output logic       o_timeout,
   output logic       o_busy
);

   localparam int               CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic             TO_EN    = (TIMEOUT_CYCLES > 0);
   localparam logic [CNT_W-1:0] TO_LAST  = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [7:0]       BLEN_CMD = bp_cmd(1'b1, 7'(BURST_ADDR));

   bp_init_state_t   state, state_nx;
   logic [7:0]       remaining, remaining_nx;
   logic [CNT_W-1:0] tcnt, tcnt_nx;
   logic             wait_tick;

   logic             wr_q;
   logic [6:0]       addr_q;
   logic [7:0]       data_q;
   logic [7:0]       len_q;

   assign o_busy = (state != IDLE);

   // Control state; everything freezes while the clock gate is closed.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= IDLE;
         remaining <= '0;
         tcnt      <= '0;
      end else if (i_cg) begin
         state     <= state_nx;
         remaining <= remaining_nx;
         tcnt      <= tcnt_nx;
      end
   end

   always_ff @(posedge i_clk) begin
      if (o_req_ready && i_req_valid) begin
         wr_q   <= i_req_wr;
         addr_q <= i_req_addr;
         data_q <= i_req_data;
         len_q  <= i_req_len;
      end
   end

   always_comb begin
      state_nx     = state;
      remaining_nx = remaining;
      tcnt_nx      = tcnt;
      wait_tick    = 1'b0;
      o_req_ready  = 1'b0;
      o_bp_data    = 8'h00;
      o_bp_valid   = 1'b0;
      o_bp_ready   = 1'b0;
      o_rsp_data   = 8'h00;
      o_rsp_valid  = 1'b0;
      o_rsp_last   = 1'b0;
      o_timeout    = 1'b0;

      case (state)
         IDLE: begin
            o_req_ready = i_cg;
            if (i_req_valid)
               state_nx = (!i_req_wr && i_req_len >= 8'd2) ? SEND_BLEN_CMD : SEND_CMD;
         end
         SEND_BLEN_CMD: begin
            o_bp_valid = i_cg;
            o_bp_data  = BLEN_CMD;
            if (i_bp_ready) state_nx = SEND_BLEN;
         end
         SEND_BLEN: begin
            o_bp_valid = i_cg;
            o_bp_data  = len_q;
            if (i_bp_ready) state_nx = DISCARD;
         end
         DISCARD: begin
            // The target echoes the old burst-length value; it is dropped here.
            o_bp_ready = i_cg;
            if (i_bp_valid) state_nx  = SEND_CMD;
            else            wait_tick = 1'b1;
         end
         SEND_CMD: begin
            o_bp_valid = i_cg;
            o_bp_data  = bp_cmd(wr_q, addr_q);
            if (i_bp_ready) begin
               if (wr_q) begin
                  state_nx = SEND_DATA;
               end else begin
                  state_nx     = RECV;
                  remaining_nx = (len_q == 8'd0) ? 8'd1 : len_q;
               end
            end
         end
         SEND_DATA: begin
            o_bp_valid = i_cg;
            o_bp_data  = data_q;
            if (i_bp_ready) begin
               state_nx     = RECV;
               remaining_nx = 8'd1;
            end
         end
         RECV: begin
            o_rsp_data  = i_bp_data;
            o_rsp_valid = i_cg && i_bp_valid;
            o_bp_ready  = i_cg && i_rsp_ready;
            o_rsp_last  = i_cg && i_bp_valid && (remaining == 8'd1);
            if (i_bp_valid && i_rsp_ready) begin
               remaining_nx = remaining - 8'd1;
               tcnt_nx      = '0;
               if (remaining == 8'd1) state_nx = IDLE;
            end else if (!i_bp_valid) begin
               wait_tick = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase

      // A byte arriving in the same cycle never counts as a wait cycle.
      if (wait_tick && TO_EN) begin
         if (tcnt == TO_LAST) begin
            o_timeout = i_cg;
            state_nx  = IDLE;
         end else begin
            tcnt_nx = tcnt + CNT_W'(1);
         end
      end
      if (state_nx != state) tcnt_nx = '0;
   end

endmodule

// File: tb/tb_bp_reg_initiator.sv
// Bench for bp_reg_initiator: vector table, stress and timeout/reset sequences,
// and random requests checked against a request-level byte model.
module tb_bp_reg_initiator;

   localparam logic [6:0] TB_BURST = 7'h00;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, cg;
   logic       req_valid, req_ready, req_wr;
   logic [6:0] req_addr;
   logic [7:0] req_data, req_len;
   logic [7:0] bp_out;
   logic       bp_out_valid, bp_out_ready;
   logic [7:0] bp_in;
   logic       bp_in_valid, bp_in_ready;
   logic [7:0] rsp_data;
   logic       rsp_valid, rsp_ready, rsp_last, timeout, busy;

   int checks   = 0;
   int failures = 0;

   logic [7:0] q_out[$];
   logic [7:0] q_in[$];
   logic [7:0] q_rsp[$];
   int         q_rel[$];

   bp_reg_initiator #(.TIMEOUT_CYCLES(8), .BURST_ADDR(0)) dut (
      .i_clk(clk), .i_rst(rst), .i_cg(cg),
      .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wr(req_wr),
      .i_req_addr(req_addr), .i_req_data(req_data), .i_req_len(req_len),
      .o_bp_data(bp_out), .o_bp_valid(bp_out_valid), .i_bp_ready(bp_out_ready),
      .i_bp_data(bp_in), .i_bp_valid(bp_in_valid), .o_bp_ready(bp_in_ready),
      .o_rsp_data(rsp_data), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_last(rsp_last), .o_timeout(timeout), .o_busy(busy)
   );

   typedef struct packed {
      logic             wr;
      logic [6:0]       addr;
      logic [7:0]       data;
      logic [7:0]       len;
      logic [3:0]       n_in;
      logic [0:4][7:0]  in_b;
      logic [1:0]       n_out;
      logic [0:2][7:0]  out_b;
      logic [2:0]       n_rsp;
      logic [0:3][7:0]  rsp_b;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s", name);
   endtask

   function automatic vec_t mk(input logic wr, input logic [6:0] a, input logic [7:0] d,
                               input logic [7:0] l, input logic [3:0] ni, input logic [0:4][7:0] ib,
                               input logic [1:0] no, input logic [0:2][7:0] ob,
                               input logic [2:0] nr, input logic [0:3][7:0] rb);
      vec_t v;
      v.wr = wr; v.addr = a; v.data = d; v.len = l;
      v.n_in = ni; v.in_b = ib; v.n_out = no; v.out_b = ob; v.n_rsp = nr; v.rsp_b = rb;
      return v;
   endfunction

   function automatic void clear_q();
      q_out.delete(); q_in.delete(); q_rsp.delete(); q_rel.delete();
   endfunction

   // Expected traffic from the request alone: bytes sent, bytes the target
   // returns, and which of those reach the response stream.
   function automatic void model(input logic wr, input logic [6:0] addr,
                                 input logic [7:0] data, input logic [7:0] len);
      int         n;
      logic [7:0] b;
      bit         burst;
      clear_q();
      burst = !wr && (len >= 8'd2);
      n     = burst ? int'(len) : 1;
      if (burst) begin
         q_out.push_back({1'b1, TB_BURST});
         q_out.push_back(len);
         b = 8'($urandom);
         q_in.push_back(b);
         q_rel.push_back(2);
      end
      q_out.push_back({wr, addr});
      if (wr) q_out.push_back(data);
      for (int i = 0; i < n; i++) begin
         b = 8'($urandom);
         q_in.push_back(b);
         q_rel.push_back(q_out.size());
         q_rsp.push_back(b);
      end
   endfunction

   function automatic void load_vec(input vec_t v);
      clear_q();
      for (int i = 0; i < int'(v.n_out); i++) q_out.push_back(v.out_b[i]);
      for (int i = 0; i < int'(v.n_rsp); i++) q_rsp.push_back(v.rsp_b[i]);
      for (int i = 0; i < int'(v.n_in); i++) begin
         q_in.push_back(v.in_b[i]);
         q_rel.push_back((i == 0 && int'(v.n_in) > int'(v.n_rsp)) ? 2 : int'(v.n_out));
      end
   endfunction

   // mode 0: no stalls; 1: 3-cycle bp stalls + toggling rsp_ready; 2: random.
   task automatic run_txn(input logic wr, input logic [6:0] addr, input logic [7:0] data,
                          input logic [7:0] len, input int mode, input int abort_after);
      int         out_cnt, rsp_cnt, cyc, st, gap, budget;
      bit         prev_stall, done, abort, saw_to, exp_last;
      logic [7:0] prev_data, e;
      out_cnt = 0; rsp_cnt = 0; cyc = 0; st = 0;
      prev_stall = 0; done = 0; abort = 0; saw_to = 0; prev_data = 8'h00;
      budget = 100 + 16 * q_in.size();
      @(negedge clk);
      req_valid = 1'b1; req_wr = wr; req_addr = addr; req_data = data; req_len = len;
      bp_in_valid = 1'b0; rsp_ready = 1'b1;
      #1;
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      req_wr = 1'($urandom_range(0, 1)); req_addr = 7'($urandom);
      req_data = 8'($urandom); req_len = 8'($urandom);
      gap = (mode == 2) ? int'($urandom_range(0, 3)) : 0;
      while (!done && !abort && cyc < budget) begin
         case (mode)
            0: begin bp_out_ready = 1'b1; rsp_ready = 1'b1; end
            1: begin bp_out_ready = (st >= 3); rsp_ready = cyc[0]; end
            default: begin
               bp_out_ready = 1'($urandom_range(0, 1));
               rsp_ready    = 1'($urandom_range(0, 1));
            end
         endcase
         if (q_in.size() > 0 && out_cnt >= q_rel[0]) begin
            if (gap > 0) begin
               gap--;
               bp_in_valid = 1'b0; bp_in = 8'($urandom);
            end else begin
               bp_in_valid = 1'b1; bp_in = q_in[0];
            end
         end else begin
            bp_in_valid = 1'b0; bp_in = 8'($urandom);
         end
         #1;
         if (prev_stall) begin
            chk("bp_hold_valid", 32'(bp_out_valid), 32'd1);
            chk("bp_hold_data", 32'(bp_out), 32'(prev_data));
         end
         prev_stall = 0;
         if (bp_out_valid) begin
            if (bp_out_ready) begin
               if (q_out.size() == 0) fail("bp_out_extra");
               else begin
                  e = q_out.pop_front();
                  chk("bp_out_byte", 32'(bp_out), 32'(e));
               end
               out_cnt++;
               st = 0;
            end else begin
               prev_stall = 1;
               prev_data  = bp_out;
               st++;
            end
         end
         if (bp_in_valid && bp_in_ready) begin
            void'(q_in.pop_front());
            void'(q_rel.pop_front());
            gap = (mode == 2) ? int'($urandom_range(0, 3)) : 0;
         end
         if (rsp_valid && rsp_ready) begin
            if (q_rsp.size() == 0) fail("rsp_extra");
            else begin
               e = q_rsp.pop_front();
               exp_last = (q_rsp.size() == 0);
               chk("rsp_byte", 32'(rsp_data), 32'(e));
               chk("rsp_last", 32'(rsp_last), 32'(exp_last));
            end
            rsp_cnt++;
            if (rsp_cnt == abort_after) abort = 1;
         end
         if (timeout) saw_to = 1;
         if (q_out.size() == 0 && q_in.size() == 0 && q_rsp.size() == 0) done = 1;
         cyc++;
         @(negedge clk);
      end
      if (!done && !abort) fail("txn_budget_expired");
      if (!abort) begin
         bp_in_valid = 1'b0;
         #1;
         chk("req_ready_after", 32'(req_ready), 32'd1);
         chk("busy_after", 32'(busy), 32'd0);
         chk("no_timeout", 32'(saw_to), 32'd0);
      end
   endtask

   task automatic silent_read(input logic [6:0] addr, input bit race);
      bit early, rsp_seen;
      early = 0; rsp_seen = 0;
      @(negedge clk);
      req_valid = 1'b1; req_wr = 1'b0; req_addr = addr; req_len = 8'd1;
      bp_out_ready = 1'b1; bp_in_valid = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk("to_cmd_valid", 32'(bp_out_valid), 32'd1);
      chk("to_cmd_data", 32'(bp_out), 32'({1'b0, addr}));
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (race && k == 8) begin bp_in_valid = 1'b1; bp_in = 8'h6C; end
         #1;
         if (k < 8) begin
            if (timeout)   early    = 1;
            if (rsp_valid) rsp_seen = 1;
         end
      end
      if (race) begin
         chk("race_timeout", 32'(timeout), 32'd0);
         chk("race_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("race_rsp_data", 32'(rsp_data), 32'h6C);
         chk("race_rsp_last", 32'(rsp_last), 32'd1);
      end else begin
         chk("to_pulse", 32'(timeout), 32'd1);
         chk("to_rsp_valid", 32'(rsp_valid), 32'd0);
         chk("to_rsp_last", 32'(rsp_last), 32'd0);
      end
      chk("to_early", 32'(early), 32'd0);
      chk("to_rsp_early", 32'(rsp_seen), 32'd0);
      @(negedge clk);
      bp_in_valid = 1'b0;
      #1;
      chk("to_idle_busy", 32'(busy), 32'd0);
      chk("to_idle_ready", 32'(req_ready), 32'd1);
      chk("to_pulse_once", 32'(timeout), 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic       w;
      logic [6:0] a;
      logic [7:0] d, l;
      rst = 1'b1; cg = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0;
      req_data = '0; req_len = '0; bp_out_ready = 1'b0; bp_in = '0;
      bp_in_valid = 1'b0; rsp_ready = 1'b0;

      vecs[0] = mk(1'b1, 7'h19, 8'h05, 8'h00, 4'd1, {8'h00, 32'h0}, 2'd2, {8'h99, 8'h05, 8'h00}, 3'd1, {8'h00, 24'h0});
      vecs[1] = mk(1'b0, 7'h1E, 8'h00, 8'h00, 4'd1, {8'h03, 32'h0}, 2'd1, {8'h1E, 16'h0}, 3'd1, {8'h03, 24'h0});
      vecs[2] = mk(1'b0, 7'h01, 8'h00, 8'h04, 4'd5, {8'h02, 8'h11, 8'h22, 8'h33, 8'h44}, 2'd3, {8'h80, 8'h04, 8'h01}, 3'd4, {8'h11, 8'h22, 8'h33, 8'h44});
      vecs[3] = mk(1'b0, 7'h42, 8'h00, 8'h01, 4'd1, {8'hA5, 32'h0}, 2'd1, {8'h42, 16'h0}, 3'd1, {8'hA5, 24'h0});
      vecs[4] = mk(1'b1, 7'h00, 8'hFF, 8'h09, 4'd1, {8'h12, 32'h0}, 2'd2, {8'h80, 8'hFF, 8'h00}, 3'd1, {8'h12, 24'h0});
      vecs[5] = mk(1'b0, 7'h7F, 8'h00, 8'h02, 4'd3, {8'h04, 8'hC3, 8'h3C, 16'h0}, 2'd3, {8'h80, 8'h02, 8'h7F}, 3'd2, {8'hC3, 8'h3C, 16'h0});
      vecs[6] = mk(1'b1, 7'h7F, 8'h00, 8'h00, 4'd1, {8'h55, 32'h0}, 2'd2, {8'hFF, 8'h00, 8'h00}, 3'd1, {8'h55, 24'h0});

      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_bp_valid", 32'(bp_out_valid), 32'd0);
      chk("rst_bp_ready", 32'(bp_in_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_last", 32'(rsp_last), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);

      // Clock gate closed: request must not be taken.
      @(negedge clk);
      cg = 1'b0; req_valid = 1'b1; req_wr = 1'b0; req_addr = 7'h10; req_len = 8'd1;
      #1;
      chk("cg_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      #1;
      chk("cg_busy", 32'(busy), 32'd0);
      req_valid = 1'b0; cg = 1'b1;

      for (int i = 0; i < 7; i++) begin
         load_vec(vecs[i]);
         run_txn(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].len, 0, 0);
      end

      load_vec(vecs[2]);
      run_txn(vecs[2].wr, vecs[2].addr, vecs[2].data, vecs[2].len, 1, 0);

      silent_read(7'h33, 1'b0);
      silent_read(7'h34, 1'b1);

      // Reset in the middle of a 4-byte burst, after two response bytes.
      load_vec(vecs[2]);
      run_txn(vecs[2].wr, vecs[2].addr, vecs[2].data, vecs[2].len, 0, 2);
      rst = 1'b1; bp_in_valid = 1'b1; rsp_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rst_bp_ready", 32'(bp_in_ready), 32'd0);
      chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
      bp_in_valid = 1'b0;
      load_vec(vecs[1]);
      run_txn(vecs[1].wr, vecs[1].addr, vecs[1].data, vecs[1].len, 0, 0);

      for (int i = 0; i < 40; i++) begin
         w = 1'($urandom_range(0, 1));
         a = 7'($urandom);
         d = 8'($urandom);
         l = 8'($urandom_range(0, 20));
         model(w, a, d, l);
         run_txn(w, a, d, l, 2, 0);
      end

      model(1'b0, 7'h2A, 8'h00, 8'hFF);
      run_txn(1'b0, 7'h2A, 8'h00, 8'hFF, 2, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
